bus_drive_decoder: RTL and testbench

- Registered 5-to-24 bus-source decoder: the decode counterpart of the datapath bus-select encoder.
- Accepts a 5-bit source code from control and produces one-hot bus drive enables: R0out..R15out, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InPortout, Cout.
- Enforces break-before-make: a turnaround gap with all enables low separates any two different drivers, so the shared bus never sees contention.
- Sits between the control unit and the bus-source enable inputs.

---
 rtl/bus_drive_decoder_if.sv | 27 ++
 rtl/bus_drive_decoder.sv | 135 +++++++++++++
 tb/tb_bus_drive_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_drive_decoder_if.sv
// Source-select handshake and drive-enable bundle
// between the control unit and the bus decoder.
interface bus_drive_decoder_if #(
   parameter int SEL_W   = 5,
   parameter int NUM_SRC = 24
);
   logic               sel_valid;
   logic [SEL_W-1:0]   sel_code;
   logic               sel_release;
   logic               sel_ready;
   logic [NUM_SRC-1:0] drive;
   logic               drive_active;
   logic               bad_code;
   logic [7:0]         hold_cnt;

   modport master (
      output sel_valid, sel_code, sel_release,
      input  sel_ready, drive, drive_active,
      input  bad_code, hold_cnt
   );

   modport slave (
      input  sel_valid, sel_code, sel_release,
      output sel_ready, drive, drive_active,
      output bad_code, hold_cnt
   );
endinterface

// File: rtl/bus_drive_decoder.sv
// Registered source-code to one-hot bus drive decoder
// with break-before-make turnaround between drivers.
module bus_drive_decoder #(
   parameter int SEL_W       = 5,
   parameter int NUM_SRC     = 24,
   parameter int TURN_CYCLES = 1
) (
   input logic clock,
   input logic clear,
   bus_drive_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      DRIVE = 2'd2
   } state_t;

   localparam logic [NUM_SRC-1:0] ONE =
      {{(NUM_SRC-1){1'b0}}, 1'b1};
   localparam logic [SEL_W:0] LIM =
      (SEL_W+1)'(NUM_SRC);
   localparam logic [1:0] TURN_LD =
      2'(TURN_CYCLES);

   state_t             state, state_n;
   logic [SEL_W-1:0]   cur_code, code_n;
   logic [1:0]         turn_cnt, turn_n;
   logic [NUM_SRC-1:0] drive_q, drive_n;
   logic [7:0]         hold_q, hold_n;
   logic               bad_q, bad_n;
   logic               act_q;

   logic               accept;
   logic               legal;
   logic [NUM_SRC-1:0] dec;
   logic [7:0]         hold_inc;

   assign accept   = bus.sel_valid && (state != TURN);
   assign legal    = {1'b0, bus.sel_code} < LIM;
   assign dec      = ONE << bus.sel_code;
   assign hold_inc = (hold_q == 8'hff) ?
                     hold_q : hold_q + 8'd1;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         cur_code <= '0;
         turn_cnt <= '0;
         drive_q  <= '0;
         hold_q   <= '0;
         bad_q    <= 1'b0;
         act_q    <= 1'b0;
      end else begin
         state    <= state_n;
         cur_code <= code_n;
         turn_cnt <= turn_n;
         drive_q  <= drive_n;
         hold_q   <= hold_n;
         bad_q    <= bad_n;
         act_q    <= |drive_n;
      end
   end

   always_comb begin
      state_n = state;
      code_n  = cur_code;
      turn_n  = turn_cnt;
      drive_n = drive_q;
      hold_n  = '0;
      bad_n   = 1'b0;
      unique case (state)
         IDLE: begin
            drive_n = '0;
            if (accept) begin
               if (!legal) begin
                  bad_n = 1'b1;
               end else begin
                  code_n = bus.sel_code;
                  if (TURN_CYCLES == 0) begin
                     state_n = DRIVE;
                     drive_n = dec;
                  end else begin
                     state_n = TURN;
                     turn_n  = TURN_LD;
                  end
               end
            end
         end
         TURN: begin
            drive_n = '0;
            turn_n  = turn_cnt - 2'd1;
            if (turn_cnt <= 2'd1) begin
               turn_n  = '0;
               state_n = DRIVE;
               drive_n = ONE << cur_code;
            end
         end
         DRIVE: begin
            hold_n = hold_inc;
            if (accept) begin
               if (!legal) begin
                  bad_n = 1'b1;
               end else if (bus.sel_code != cur_code) begin
                  // new driver: bus goes quiet before it takes over
                  code_n = bus.sel_code;
                  hold_n = '0;
                  if (TURN_CYCLES == 0) begin
                     drive_n = dec;
                  end else begin
                     drive_n = '0;
                     state_n = TURN;
                     turn_n  = TURN_LD;
                  end
               end
            end else if (bus.sel_release) begin
               drive_n = '0;
               hold_n  = '0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            drive_n = '0;
         end
      endcase
   end

   assign bus.sel_ready    = (state != TURN);
   assign bus.drive        = drive_q;
   assign bus.drive_active = act_q;
   assign bus.bad_code     = bad_q;
   assign bus.hold_cnt     = hold_q;

endmodule

// File: tb/tb_bus_drive_decoder.sv
// Scoreboard bench for bus_drive_decoder with
// turnaround lengths 0, 1 and 3.
module tb_bus_drive_decoder;

   logic clock = 1'b0;
   logic clear = 1'b0;
   always #5 clock = ~clock;

   bus_drive_decoder_if #(.SEL_W(5), .NUM_SRC(24)) b0 ();
   bus_drive_decoder_if #(.SEL_W(5), .NUM_SRC(24)) b1 ();
   bus_drive_decoder_if #(.SEL_W(5), .NUM_SRC(24)) b3 ();

   bus_drive_decoder #(.TURN_CYCLES(0)) u0 (
      .clock(clock), .clear(clear), .bus(b0.slave));
   bus_drive_decoder #(.TURN_CYCLES(1)) u1 (
      .clock(clock), .clear(clear), .bus(b1.slave));
   bus_drive_decoder #(.TURN_CYCLES(3)) u3 (
      .clock(clock), .clear(clear), .bus(b3.slave));

   typedef struct packed {
      logic [23:0] d;
      logic [7:0]  h;
      logic        bad;
      logic        rdy;
      logic        act;
   } exp_t;

   typedef struct packed {
      logic [1:0] u;
      logic       v;
      logic [4:0] c;
      logic       r;
      exp_t       e;
   } step_t;

   step_t plan[$];
   exp_t  q[$];
   int    checks   = 0;
   int    failures = 0;

   function automatic logic [23:0] bit_of(int n);
      logic [23:0] one;
      one = 24'h1;
      return one << n;
   endfunction

   function automatic exp_t mk(logic [23:0] d,
         logic [7:0] h, logic bad, logic rdy);
      exp_t e;
      e.d = d; e.h = h; e.bad = bad;
      e.rdy = rdy; e.act = |d;
      return e;
   endfunction

   function automatic void add(logic [1:0] u,
         logic v, logic [4:0] c, logic r,
         logic [23:0] d, logic [7:0] h,
         logic bad, logic rdy);
      step_t s;
      s.u = u; s.v = v; s.c = c; s.r = r;
      s.e = mk(d, h, bad, rdy);
      plan.push_back(s);
   endfunction

   function automatic exp_t sample(logic [1:0] u);
      exp_t g;
      case (u)
         2'd0: g = {b0.drive, b0.hold_cnt, b0.bad_code,
                    b0.sel_ready, b0.drive_active};
         2'd1: g = {b1.drive, b1.hold_cnt, b1.bad_code,
                    b1.sel_ready, b1.drive_active};
         default: g = {b3.drive, b3.hold_cnt, b3.bad_code,
                       b3.sel_ready, b3.drive_active};
      endcase
      return g;
   endfunction

   task automatic apply(input step_t s);
      b0.sel_valid = 0; b0.sel_code = 0; b0.sel_release = 0;
      b1.sel_valid = 0; b1.sel_code = 0; b1.sel_release = 0;
      b3.sel_valid = 0; b3.sel_code = 0; b3.sel_release = 0;
      case (s.u)
         2'd0: begin
            b0.sel_valid = s.v; b0.sel_code = s.c;
            b0.sel_release = s.r;
         end
         2'd1: begin
            b1.sel_valid = s.v; b1.sel_code = s.c;
            b1.sel_release = s.r;
         end
         default: begin
            b3.sel_valid = s.v; b3.sel_code = s.c;
            b3.sel_release = s.r;
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      exp_t g, e;
      step_t s;
      e = mk(24'h0, 8'd0, 1'b0, 1'b1);
      g = sample(2'd1);
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL reset_initial got=%h exp=%h", g, e);
      end
      add(1, 1, 20, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, bit_of(20), 0, 0, 1);
      add(1, 0, 0, 0, bit_of(20), 1, 0, 1);
      add(1, 0, 0, 0, bit_of(20), 2, 0, 1);
      while (plan.size() != 0) begin
         s = plan.pop_front();
         apply(s);
         q.push_back(s.e);
         tick();
         g = sample(s.u);
         e = q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL reset_setup got=%h exp=%h", g, e);
         end
      end
      clear = 1'b0;
      #2;
      e = mk(24'h0, 8'd0, 1'b0, 1'b1);
      g = sample(2'd1);
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", g, e);
      end
      clear = 1'b1;
      #2;
      g = sample(2'd1);
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL reset_release got=%h exp=%h", g, e);
      end
   endtask

   task automatic test_decode();
      exp_t g, e;
      step_t s;
      add(1, 1, 5, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 24'h000020, 0, 0, 1);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      for (int c = 0; c < 24; c++) begin
         add(1, 1, 5'(c), 0, 0, 0, 0, 0);
         add(1, 0, 0, 0, bit_of(c), 0, 0, 1);
         add(1, 0, 0, 1, 0, 0, 0, 1);
      end
      while (plan.size() != 0) begin
         s = plan.pop_front();
         apply(s);
         q.push_back(s.e);
         tick();
         g = sample(s.u);
         e = q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL decode code=%0d got=%h exp=%h",
                     s.c, g, e);
         end
      end
   endtask

   task automatic test_switch();
      exp_t g, e;
      step_t s;
      add(1, 1, 3, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 24'h000008, 0, 0, 1);
      add(1, 0, 0, 0, 24'h000008, 1, 0, 1);
      add(1, 1, 21, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 24'h200000, 0, 0, 1);
      add(1, 1, 3, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 24'h000008, 0, 0, 1);
      add(1, 1, 3, 0, 24'h000008, 1, 0, 1);
      add(1, 1, 3, 0, 24'h000008, 2, 0, 1);
      add(1, 0, 0, 0, 24'h000008, 3, 0, 1);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         s = plan.pop_front();
         apply(s);
         q.push_back(s.e);
         tick();
         g = sample(s.u);
         e = q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL switch got=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_illegal();
      exp_t g, e;
      step_t s;
      add(1, 1, 24, 0, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 0, 0, 1);
      add(1, 1, 31, 0, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 0, 0, 1);
      add(1, 1, 16, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 24'h010000, 0, 0, 1);
      add(1, 1, 30, 0, 24'h010000, 1, 1, 1);
      add(1, 0, 0, 0, 24'h010000, 2, 0, 1);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         s = plan.pop_front();
         apply(s);
         q.push_back(s.e);
         tick();
         g = sample(s.u);
         e = q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL illegal got=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_release();
      exp_t g, e;
      step_t s;
      add(1, 1, 7, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 24'h000080, 0, 0, 1);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      add(1, 1, 7, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 24'h000080, 0, 0, 1);
      add(1, 1, 9, 1, 0, 0, 0, 0);
      add(1, 0, 0, 0, 24'h000200, 0, 0, 1);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         s = plan.pop_front();
         apply(s);
         q.push_back(s.e);
         tick();
         g = sample(s.u);
         e = q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL release got=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_hold();
      exp_t g, e;
      step_t s;
      add(1, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++)
         add(1, 0, 0, 0, 24'h000001,
             8'((i > 255) ? 255 : i), 0, 1);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         s = plan.pop_front();
         apply(s);
         q.push_back(s.e);
         tick();
         g = sample(s.u);
         e = q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL hold got=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_turn_variants();
      exp_t g, e;
      step_t s;
      add(0, 1, 2, 0, 24'h000004, 0, 0, 1);
      add(0, 0, 0, 0, 24'h000004, 1, 0, 1);
      add(0, 1, 6, 0, 24'h000040, 0, 0, 1);
      add(0, 0, 0, 0, 24'h000040, 1, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0, 1);
      add(2, 1, 2, 0, 0, 0, 0, 0);
      add(2, 0, 0, 1, 0, 0, 0, 0);
      add(2, 0, 0, 0, 0, 0, 0, 0);
      add(2, 0, 0, 0, 24'h000004, 0, 0, 1);
      add(2, 1, 6, 0, 0, 0, 0, 0);
      add(2, 1, 6, 0, 0, 0, 0, 0);
      add(2, 0, 0, 0, 0, 0, 0, 0);
      add(2, 0, 0, 0, 24'h000040, 0, 0, 1);
      add(2, 0, 0, 1, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         s = plan.pop_front();
         apply(s);
         q.push_back(s.e);
         tick();
         g = sample(s.u);
         e = q.pop_front();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL turn_dut%0d got=%h exp=%h",
                     s.u, g, e);
         end
      end
   endtask

   initial begin
      step_t z;
      z = '0;
      apply(z);
      #12;
      clear = 1'b1;
      #1;
      test_reset();
      test_decode();
      test_switch();
      test_illegal();
      test_release();
      test_hold();
      test_turn_variants();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
